// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the time_set_controller block: editor
// state encoding, field limits, target selection and the wrap-around step.
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOUR   = 2'd1,
    MIN    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic {
    TIME  = 1'b0,
    ALARM = 1'b1
  } target_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // One up/down step with wrap-around; both or neither pressed holds.
  // The ">=" guard keeps an out-of-range value from sticking.
  function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                           input logic [5:0] max_value,
                                           input logic       up,
                                           input logic       down);
    logic [5:0] result;
    result = value;
    if (up && !down) begin
      result = (value >= max_value) ? 6'd0 : value + 6'd1;
    end else if (down && !up) begin
      result = (value == 6'd0) ? max_value : value - 6'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/time_set_controller_bin_to_digits.sv
// bin_to_digits: splits a 0..59 binary value into decimal tens and units.
// TENS_W lets the hour instance drive its 2-bit tens digit directly.
module bin_to_digits #(
  parameter int TENS_W = 4
) (
  input  logic [5:0]        bin,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        units
);

  // Threshold chain instead of a divider: at most five compares against 10..50.
  always_comb begin
    logic [5:0] tens_x10;
    tens     = '0;
    tens_x10 = 6'd0;
    for (int i = 1; i <= 5; i++) begin
      if (bin >= 6'(i * 10)) begin
        tens     = TENS_W'(i);
        tens_x10 = 6'(i * 10);
      end
    end
    units = 4'(bin - tens_x10);
  end

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven HH:MM entry for the alarm clock core.
// btn_set enters edit, advances hour -> minute, then commits with a one-cycle
// load_time or load_alarm strobe. btn_up/btn_down step the active field once
// per clock_1s edge while held.
// Optional feature macro: TIME_SET_TIMEOUT_EN -- abandons an edit after
// TIMEOUT_S seconds without button activity (no strobe is issued).
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       reset,
  input  logic       clock_1s,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic       edit_field,
  output logic       blink
);

  state_t     state;
  target_t    target;
  logic [4:0] hour;
  logic [5:0] minute;
  logic       set_q;
  logic       set_edge;
  logic [7:0] seed_hour;
  logic [7:0] seed_min;

  assign set_edge = btn_set & ~set_q;

  // Seed values from the displayed time; worst case 3*10+15 and 15*10+15 fit 8 bits.
  assign seed_hour = 8'(cur_hour1) * 8'd10 + 8'(cur_hour0);
  assign seed_min  = 8'(cur_min1) * 8'd10 + 8'(cur_min0);

`ifdef TIME_SET_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S);
  logic [CNT_W-1:0] timeout_cnt;
`else
  // Timeout is compiled out; the parameter is intentionally left unused.
  wire unused_timeout_s = (TIMEOUT_S == 0);
`endif

  // Editor FSM with registered strobes, blink, target and field registers.
  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target     <= TIME;
      hour       <= 5'd0;
      minute     <= 6'd0;
      set_q      <= 1'b0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      blink      <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      set_q      <= btn_set;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      case (state)
        IDLE: begin
          blink <= 1'b0;
          if (set_edge) begin
            target <= target_t'(btn_mode);
            hour   <= (seed_hour > 8'(MAX_HOUR)) ? 5'd0 : seed_hour[4:0];
            minute <= (seed_min > 8'(MAX_MIN)) ? 6'd0 : seed_min[5:0];
            state  <= HOUR;
            blink  <= 1'b1;
`ifdef TIME_SET_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
        end
        HOUR: begin
          blink <= ~blink;
          if (set_edge) begin
            state <= MIN;
          end else begin
            hour <= 5'(step_wrap({1'b0, hour}, {1'b0, MAX_HOUR}, btn_up, btn_down));
          end
        end
        MIN: begin
          blink <= ~blink;
          if (set_edge) begin
            state      <= COMMIT;
            blink      <= 1'b0;
            load_time  <= (target == TIME);
            load_alarm <= (target == ALARM);
          end else begin
            minute <= step_wrap(minute, MAX_MIN, btn_up, btn_down);
          end
        end
        default: begin
          // COMMIT: strobe was raised on entry; always fall back to IDLE.
          state <= IDLE;
          blink <= 1'b0;
        end
      endcase
`ifdef TIME_SET_TIMEOUT_EN
      // Inactivity watchdog: only idle cycles in HOUR/MIN count toward abandon.
      if (state == HOUR || state == MIN) begin
        if (set_edge || btn_up || btn_down) begin
          timeout_cnt <= '0;
        end else if (timeout_cnt == CNT_W'(TIMEOUT_S - 1)) begin
          timeout_cnt <= '0;
          state       <= IDLE;
          blink       <= 1'b0;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end
`endif
    end
  end

  // Editing indicators decode directly from the state register.
  assign editing    = (state == HOUR) || (state == MIN);
  assign edit_field = (state == MIN);

  bin_to_digits #(.TENS_W(2)) u_hour_digits (
    .bin   ({1'b0, hour}),
    .tens  (hour_in1),
    .units (hour_in0)
  );

  bin_to_digits #(.TENS_W(4)) u_min_digits (
    .bin   (minute),
    .tens  (minute_in1),
    .units (minute_in0)
  );

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Button-driven time-entry controller that drives the set-time/set-alarm side of the alarm clock: it produces the `hour_in*`/`minute_in*` digit buses and the `load_time`/`load_alarm` strobes that the clock core consumes. Runs on the 1 Hz `clock_1s` domain, the same edge the clock core samples on. A held up/down button therefore auto-repeats at one step per second. Sits between the board push-buttons (after the debouncer) and the clock core.

## Interface
- `TIMEOUT_S`, default 10: idle seconds before an edit is abandoned (used only with the timeout feature).
- `reset` in 1: asynchronous, active-high.
- `clock_1s` in 1: clock, 1 Hz tick from the slow-clock divider.
- `btn_set` in 1: enter edit / advance field / commit. Acts on its rising edge.
- `btn_up` in 1: level; increments the active field once per cycle while high.
- `btn_down` in 1: level; decrements the active field once per cycle while high.
- `btn_mode` in 1: target select, sampled on edit entry only. 0 = time, 1 = alarm.
- `cur_hour1` in 2, `cur_hour0` in 4, `cur_min1` in 4, `cur_min0` in 4: current displayed time digits, used as the seed value.
- `hour_in1` out 2, `hour_in0` out 4, `minute_in1` out 4, `minute_in0` out 4: edited value as decimal digits.
- `load_time` out 1, `load_alarm` out 1: one-cycle commit strobes.
- `editing` out 1: high in HOUR and MIN.
- `edit_field` out 1: 0 = hour, 1 = minute.
- `blink` out 1: toggles every cycle while editing, for field flashing.

## Operation
- Internal state:
  - `hour` 5-bit binary, 0..23.
  - `minute` 6-bit binary, 0..59.
  - `target` 1 bit.
  - `set_q` 1 bit, registered copy of `btn_set`.
  - `set_edge = btn_set & ~set_q`.
- States are IDLE, HOUR, MIN, COMMIT.
- IDLE:
  - On `set_edge`: latch `target <= btn_mode`, seed `hour = cur_hour1*10+cur_hour0`, seed `minute = cur_min1*10+cur_min0`, go to HOUR.
  - A seed hour above 23 or seed minute above 59 loads 0 instead.
- HOUR:
  - `btn_up` only: hour+1, wrapping 23 -> 0.
  - `btn_down` only: hour-1, wrapping 0 -> 23.
  - Both or neither pressed: hold.
  - `set_edge` goes to MIN. Any up/down press in that same cycle is ignored.
- MIN: same rules with wrap 59 <-> 0. `set_edge` goes to COMMIT.
- COMMIT: assert `load_time` (target=0) or `load_alarm` (target=1) for exactly this one cycle, then go to IDLE unconditionally.
- `btn_mode` changes after edit entry are ignored.
- Digit outputs are a combinational split of `hour`/`minute` (tens and units). They always reflect the registers, and are stable through COMMIT and while IDLE.
- The two load strobes are never high together, and are never high outside COMMIT.
- Button presses shorter than one `clock_1s` period may be missed; the upstream debouncer stretches presses to at least 1 s.

## Timing
- Reset values:
  - State IDLE, `hour`=0, `minute`=0, `target`=0, `set_q`=0.
  - All `*_in` digits 0.
  - `load_time`, `load_alarm`, `editing`, `edit_field`, `blink` all 0.
- Reset asserted mid-edit or in COMMIT: abort immediately. No strobe is issued, and any strobe already high drops asynchronously.
- Strobe timing:
  - Registered outputs; high from clock edge N to N+1.
  - The clock core captures on edge N+1 with stable digits.
  - From the `set_edge` in MIN, the strobe is high on the next edge: latency 1 cycle.
- Increments take effect at the edge where the button is sampled high, giving one step per second.
- `blink`: 0 in IDLE/COMMIT; starts at 1 on the first HOUR cycle.

## Configuration
- `TIME_SET_TIMEOUT_EN` defined: a counter clears on any cycle in HOUR/MIN with `btn_up`, `btn_down` or `set_edge` active, and increments otherwise.
  - When it reaches `TIMEOUT_S`, go to IDLE with no strobe.
  - The counter is reset to 0 by `reset` and on entry to HOUR.
- Not defined: no counter; editing persists indefinitely and `TIMEOUT_S` is unused.

## Structure
- Shared package holds:
  - State enum: IDLE, HOUR, MIN, COMMIT.
  - Constants `MAX_HOUR`=23 and `MAX_MIN`=59.
  - Target encodings: TIME=0, ALARM=1.
- Sub-module `bin_to_digits`: 6-bit binary 0..59 to tens/units digits. Instantiated twice, for hour and minute.

## Test plan
- Reset, then time seed 12:34 with `btn_mode`=0:
  - Pulse `btn_set` three times, no up/down.
  - Expect `load_time`=1 for one cycle with digits 1,2,3,4 and `load_alarm`=0.
- Wrap-around, with `btn_mode`=1:
  - Seed 23:58. Enter, hold `btn_up` 1 cycle, so hour becomes 0.
  - Advance, hold `btn_up` 3 cycles, so minute goes 59 -> 0 -> 1.
  - Commit: expect `load_alarm` with digits 0,0,0,1.
- Decrement wrap:
  - Seed 00:00, hold `btn_down` 1 cycle in HOUR: expect hour 23.
  - Both buttons held in MIN: minute unchanged.
- Invalid seed: `cur_hour1`=2, `cur_hour0`=7 -> hour seeds 0. `btn_mode` toggled mid-edit -> `load_time` (not `load_alarm`) on commit.
- Reset asserted in MIN after edits:
  - Expect all outputs 0 immediately and no strobe afterwards.
  - A fresh `btn_set` restarts from IDLE.
- With `TIME_SET_TIMEOUT_EN`, `TIMEOUT_S`=10:
  - Idle 10 cycles in HOUR: return to IDLE with no strobe.
  - An up press at cycle 9 extends the edit by a further 10 cycles.
